wb_stage: RTL and testbench

Write-back stage of the five-stage LoongArch32 pipeline, directly downstream of the memory stage. It consumes the 169-bit memory-to-WB bus and retires each instruction by writing the register file and the control/status registers. It commits exceptions and `ertn`, redirects fetch, and broadcasts the pipeline flush. It also owns the CSR file, including the constant-frequency timer, and generates the interrupt-pending request for decode.

---
 rtl/wb_stage_if.sv | 9 +
 rtl/wb_stage.sv | 181 ++++++++++++++++++
 tb/tb_wb_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Memory-to-writeback handshake: valid, the 169-bit instruction bus and allowin.
interface wb_stage_if;
  logic         ms_to_ws_valid;
  logic [168:0] ms_to_ws_bus;
  logic         ws_allowin;

  modport master (output ms_to_ws_valid, output ms_to_ws_bus, input  ws_allowin);
  modport slave  (input  ms_to_ws_valid, input  ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage.sv
// LoongArch32 write-back stage: retires to the regfile, commits exceptions/ertn,
// and owns the CSR file including the constant-frequency timer.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   ms_ws,
  input  logic [7:0]  hw_int_in,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  ws_to_ds_dest,
  output logic [31:0] ws_to_ds_value,
  output logic        ws_reflush_ms,
  output logic [31:0] flush_pc,
  output logic        has_int,
  output logic        ws_csr,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);
  localparam logic [13:0] CSR_CRMD   = 14'h00, CSR_PRMD  = 14'h01, CSR_ECFG  = 14'h04,
                          CSR_ESTAT  = 14'h05, CSR_ERA   = 14'h06, CSR_BADV  = 14'h07,
                          CSR_EENTRY = 14'h0C, CSR_SAVE0 = 14'h30, CSR_SAVE1 = 14'h31,
                          CSR_SAVE2  = 14'h32, CSR_SAVE3 = 14'h33, CSR_TID   = 14'h40,
                          CSR_TCFG   = 14'h41, CSR_TVAL  = 14'h42, CSR_TICLR = 14'h44;

  logic         ws_valid_q, ws_valid_d;
  logic [168:0] bus_q, bus_d;
  logic [1:0]   plv_q, plv_d, pplv_q, pplv_d, is_sw_q, is_sw_d;
  logic         ie_q, ie_d, da_q, da_d, pie_q, pie_d, is_ti_q, is_ti_d;
  logic [12:0]  lie_q, lie_d;
  logic [7:0]   is_hw_q, is_hw_d;
  logic [5:0]   ecode_q, ecode_d;
  logic [8:0]   esub_q, esub_d;
  logic [31:0]  era_q, era_d, badv_q, badv_d, tid_q, tid_d, tcfg_q, tcfg_d, tval_q, tval_d;
  logic [25:0]  eentry_q, eentry_d;
  logic [31:0]  save_q [4];
  logic [31:0]  save_d [4];
  logic         has_int_q, has_int_d;

  logic [31:0]  ws_pc, ws_result, ws_vaddr, ws_wmask;
  logic [4:0]   ws_dest;
  logic [16:0]  ws_cause;
  logic [13:0]  ws_csr_num;
  logic         ws_gr_we, ws_csr_rd, ws_csr_we, ws_ertn, ws_rdcntid;

  assign {ws_rdcntid, ws_vaddr, ws_ertn, ws_csr_we, ws_csr_rd, ws_wmask, ws_csr_num,
          ws_cause, ws_gr_we, ws_dest, ws_result, ws_pc} = bus_q;

  logic        ex, csr_wr, timer_fire;
  logic [5:0]  ex_code;
  logic [12:0] is_all;
  logic [31:0] csr_rdata, csr_wval;

  assign ex     = ws_valid_q & (|ws_cause);
  assign csr_wr = ws_valid_q & ws_csr_we & ~ex;
  assign is_all = {1'b0, is_ti_q, 1'b0, is_hw_q, is_sw_q};

  always_comb begin
    ex_code = 6'hD;
    if      (ws_cause[1]) ex_code = 6'h0;
    else if (ws_cause[0]) ex_code = 6'h8;
    else if (ws_cause[4]) ex_code = 6'hD;
    else if (ws_cause[2]) ex_code = 6'hB;
    else if (ws_cause[3]) ex_code = 6'hC;
    else if (ws_cause[5]) ex_code = 6'h9;
  end

  always_comb begin
    csr_rdata = '0;
    case (ws_csr_num)
      CSR_CRMD:   csr_rdata = {28'b0, da_q, ie_q, plv_q};
      CSR_PRMD:   csr_rdata = {29'b0, pie_q, pplv_q};
      CSR_ECFG:   csr_rdata = {19'b0, lie_q};
      CSR_ESTAT:  csr_rdata = {1'b0, esub_q, ecode_q, 3'b0, is_all};
      CSR_ERA:    csr_rdata = era_q;
      CSR_BADV:   csr_rdata = badv_q;
      CSR_EENTRY: csr_rdata = {eentry_q, 6'b0};
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: csr_rdata = save_q[ws_csr_num[1:0]];
      CSR_TID:    csr_rdata = tid_q;
      CSR_TCFG:   csr_rdata = tcfg_q;
      CSR_TVAL:   csr_rdata = tval_q;
      default:    csr_rdata = '0;
    endcase
  end

  assign csr_wval = (csr_rdata & ~ws_wmask) | (ws_result & ws_wmask);

  always_comb begin
    ws_valid_d = ms_ws.ms_to_ws_valid;
    bus_d      = ms_ws.ms_to_ws_valid ? ms_ws.ms_to_ws_bus : bus_q;
    plv_d = plv_q; ie_d = ie_q; da_d = da_q; pplv_d = pplv_q; pie_d = pie_q;
    lie_d = lie_q; is_sw_d = is_sw_q; is_ti_d = is_ti_q;
    ecode_d = ecode_q; esub_d = esub_q; era_d = era_q; badv_d = badv_q;
    eentry_d = eentry_q; save_d = save_q; tid_d = tid_q; tcfg_d = tcfg_q;
    tval_d = tval_q; timer_fire = 1'b0;
    is_hw_d = hw_int_in;

    if (csr_wr) begin
      case (ws_csr_num)
        CSR_CRMD:   begin plv_d = csr_wval[1:0]; ie_d = csr_wval[2]; da_d = csr_wval[3]; end
        CSR_PRMD:   begin pplv_d = csr_wval[1:0]; pie_d = csr_wval[2]; end
        CSR_ECFG:   lie_d = csr_wval[12:0] & 13'h0BFF;
        CSR_ESTAT:  is_sw_d = csr_wval[1:0];
        CSR_ERA:    era_d = csr_wval;
        CSR_BADV:   badv_d = csr_wval;
        CSR_EENTRY: eentry_d = csr_wval[31:6];
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: save_d[ws_csr_num[1:0]] = csr_wval;
        CSR_TID:    tid_d = csr_wval;
        CSR_TCFG:   tcfg_d = csr_wval;
        CSR_TICLR:  if (csr_wval[0]) is_ti_d = 1'b0;
        default:    ;
      endcase
    end

    // A TCFG write preempts the running count; the 1->0 tick beats a same-cycle TICLR.
    if (csr_wr && ws_csr_num == CSR_TCFG) begin
      tval_d = {csr_wval[31:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != '0) begin
        tval_d     = tval_q - 32'd1;
        timer_fire = (tval_q == 32'd1);
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end
    end
    if (timer_fire) is_ti_d = 1'b1;

    if (ex) begin
      pplv_d  = plv_q;
      pie_d   = ie_q;
      plv_d   = 2'b00;
      ie_d    = 1'b0;
      era_d   = ws_pc;
      ecode_d = ex_code;
      esub_d  = '0;
      if (!ws_cause[1] && ws_cause[0])                badv_d = ws_pc;
      else if (!(|ws_cause[4:0]) && ws_cause[5])      badv_d = ws_vaddr;
    end else if (ws_valid_q && ws_ertn) begin
      plv_d = pplv_q;
      ie_d  = pie_q;
    end

    has_int_d = ie_q & (|(is_all & lie_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0; bus_q <= '0;
      plv_q <= '0; ie_q <= 1'b0; da_q <= 1'b1; pplv_q <= '0; pie_q <= 1'b0;
      lie_q <= '0; is_sw_q <= '0; is_hw_q <= '0; is_ti_q <= 1'b0;
      ecode_q <= '0; esub_q <= '0; era_q <= '0; badv_q <= '0; eentry_q <= '0;
      for (int unsigned i = 0; i < 4; i++) save_q[i] <= '0;
      tid_q <= '0; tcfg_q <= '0; tval_q <= '1; has_int_q <= 1'b0;
    end else begin
      ws_valid_q <= ws_valid_d; bus_q <= bus_d;
      plv_q <= plv_d; ie_q <= ie_d; da_q <= da_d; pplv_q <= pplv_d; pie_q <= pie_d;
      lie_q <= lie_d; is_sw_q <= is_sw_d; is_hw_q <= is_hw_d; is_ti_q <= is_ti_d;
      ecode_q <= ecode_d; esub_q <= esub_d; era_q <= era_d; badv_q <= badv_d;
      eentry_q <= eentry_d;
      for (int unsigned i = 0; i < 4; i++) save_q[i] <= save_d[i];
      tid_q <= tid_d; tcfg_q <= tcfg_d; tval_q <= tval_d; has_int_q <= has_int_d;
    end
  end

  assign ms_ws.ws_allowin = 1'b1;
  assign rf_we            = ws_valid_q & ws_gr_we & ~ex;
  assign rf_waddr         = ws_dest;
  assign rf_wdata         = ws_csr_rd ? csr_rdata : (ws_rdcntid ? tid_q : ws_result);
  assign ws_to_ds_dest    = rf_we ? rf_waddr : 5'd0;
  assign ws_to_ds_value   = rf_we ? rf_wdata : 32'd0;
  assign ws_reflush_ms    = ws_valid_q & (ex | ws_ertn);
  assign flush_pc         = ex ? {eentry_q, 6'b0} : era_q;
  assign has_int          = has_int_q;
  assign ws_csr           = ws_valid_q & (ws_csr_we | ws_csr_rd);
  assign debug_wb_pc      = ws_pc;
  assign debug_wb_rf_we   = {4{rf_we}};
  assign debug_wb_rf_wnum = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for retire/CSR/exception behaviour,
// then hand sequences for interrupt latency, the timer and mid-instruction reset.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  hw_int_in;
  logic        rf_we, ws_reflush_ms, has_int, ws_csr;
  logic [4:0]  rf_waddr, ws_to_ds_dest, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, ws_to_ds_value, flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;

  wb_stage_if ms_ws ();

  wb_stage dut (
    .clk(clk), .reset(reset), .ms_ws(ms_ws), .hw_int_in(hw_int_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_to_ds_dest(ws_to_ds_dest), .ws_to_ds_value(ws_to_ds_value),
    .ws_reflush_ms(ws_reflush_ms), .flush_pc(flush_pc), .has_int(has_int),
    .ws_csr(ws_csr), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] CRMD = 14'h00, PRMD = 14'h01, ECFG = 14'h04, ESTAT = 14'h05,
                          ERA = 14'h06, BADV = 14'h07, EENTRY = 14'h0C, SAVE0 = 14'h30,
                          TID = 14'h40, TCFG = 14'h41, TVAL = 14'h42, TICLR = 14'h44;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [168:0] b);
    @(negedge clk);
    ms_ws.ms_to_ws_valid = v;
    ms_ws.ms_to_ws_bus   = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [168:0] mk(input logic [31:0] pc, input logic gr_we,
      input logic [4:0] dest, input logic [31:0] res, input logic [16:0] cause,
      input logic [13:0] num, input logic [31:0] mask, input logic rd, input logic we,
      input logic ertn, input logic [31:0] vaddr, input logic tid);
    return {tid, vaddr, ertn, we, rd, mask, num, cause, gr_we, dest, res, pc};
  endfunction

  function automatic logic [168:0] alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    return mk(pc, 1'b1, d, r, 17'h0, 14'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endfunction
  function automatic logic [168:0] crd(input logic [13:0] n);
    return mk(32'h1c001000, 1'b1, 5'd1, 32'h0, 17'h0, n, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endfunction
  function automatic logic [168:0] cxchg(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
    return mk(32'h1c002000, 1'b1, 5'd2, v, 17'h0, n, m, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endfunction
  function automatic logic [168:0] cwr(input logic [13:0] n, input logic [31:0] v);
    return cxchg(n, v, 32'hFFFFFFFF);
  endfunction
  function automatic logic [168:0] exc(input logic [31:0] pc, input logic [16:0] c, input logic [31:0] va);
    return mk(pc, 1'b1, 5'd6, 32'hDEAD, c, 14'h0, 32'h0, 1'b0, 1'b0, 1'b0, va, 1'b0);
  endfunction
  function automatic logic [168:0] ertn_i(input logic [31:0] pc);
    return mk(pc, 1'b0, 5'd0, 32'h0, 17'h0, 14'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
  endfunction

  typedef struct {
    string        name;
    logic [168:0] bus;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic         fl;
    logic [31:0]  fpc;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input string n, input logic [168:0] b, input logic we,
      input logic [4:0] wa, input logic [31:0] wd, input logic fl, input logic [31:0] fpc);
    vec_t v;
    v.name = n; v.bus = b; v.we = we; v.wa = wa; v.wd = wd; v.fl = fl; v.fpc = fpc;
    tv.push_back(v);
  endfunction

  // CSR reads land in r1, CSR writes/exchanges return the old value into r2.
  initial begin
    logic [168:0] b;
    logic exp_csr;

    reset = 1'b1; hw_int_in = 8'h0;
    ms_ws.ms_to_ws_valid = 1'b0; ms_ws.ms_to_ws_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.allowin", 32'(ms_ws.ws_allowin), 32'd1);
    chk("rst.rf_we",   32'(rf_we), 32'd0);
    chk("rst.flush",   32'(ws_reflush_ms), 32'd0);
    chk("rst.has_int", 32'(has_int), 32'd0);
    chk("rst.ws_csr",  32'(ws_csr), 32'd0);
    chk("rst.dbg_we",  32'(debug_wb_rf_we), 32'd0);
    @(negedge clk); reset = 1'b0;

    add("ld",          alu(32'h1c000010, 5'd5, 32'h1234), 1, 5, 32'h1234, 0, 0);
    add("crmd_rst",    crd(CRMD),  1, 1, 32'h8, 0, 0);
    add("tval_rst",    crd(TVAL),  1, 1, 32'hFFFFFFFF, 0, 0);
    add("eentry_w1",   cwr(EENTRY, 32'h1c008000), 1, 2, 32'h0, 0, 0);
    add("eentry_w2",   cwr(EENTRY, 32'h1c00807F), 1, 2, 32'h1c008000, 0, 0);
    add("eentry_w3",   cwr(EENTRY, 32'h1c008000), 1, 2, 32'h1c008040, 0, 0);
    add("crmd_w",      cwr(CRMD, 32'hFFFFFFF7), 1, 2, 32'h8, 0, 0);
    add("crmd_rd",     crd(CRMD),  1, 1, 32'h7, 0, 0);
    add("sys",         exc(32'h1c000020, 17'h4, 0), 0, 6, 0, 1, 32'h1c008000);
    add("sys_era",     crd(ERA),   1, 1, 32'h1c000020, 0, 0);
    add("sys_estat",   crd(ESTAT), 1, 1, 32'h000B0000, 0, 0);
    add("sys_prmd",    crd(PRMD),  1, 1, 32'h7, 0, 0);
    add("sys_crmd",    crd(CRMD),  1, 1, 32'h0, 0, 0);
    add("ertn",        ertn_i(32'h1c000100), 0, 0, 0, 1, 32'h1c000020);
    add("ertn_crmd",   crd(CRMD),  1, 1, 32'h7, 0, 0);
    add("save0_w",     cwr(SAVE0, 32'hFFFF0000), 1, 2, 32'h0, 0, 0);
    add("csrxchg",     cxchg(SAVE0, 32'h12345678, 32'h0000FFFF), 1, 2, 32'hFFFF0000, 0, 0);
    add("save0_rd",    crd(SAVE0), 1, 1, 32'hFFFF5678, 0, 0);
    add("ale",         exc(32'h1c000030, 17'h20, 32'h103), 0, 6, 0, 1, 32'h1c008000);
    add("ale_badv",    crd(BADV),  1, 1, 32'h103, 0, 0);
    add("ale_estat",   crd(ESTAT), 1, 1, 32'h00090000, 0, 0);
    add("adef",        exc(32'h1c000002, 17'h1, 32'h55), 0, 6, 0, 1, 32'h1c008000);
    add("adef_badv",   crd(BADV),  1, 1, 32'h1c000002, 0, 0);
    add("adef_estat",  crd(ESTAT), 1, 1, 32'h00080000, 0, 0);
    add("ine_pri",     exc(32'h1c000034, 17'h1C, 0), 0, 6, 0, 1, 32'h1c008000);
    add("ine_estat",   crd(ESTAT), 1, 1, 32'h000D0000, 0, 0);
    add("sysbrk",      exc(32'h1c000038, 17'h0C, 0), 0, 6, 0, 1, 32'h1c008000);
    add("sysbrk_est",  crd(ESTAT), 1, 1, 32'h000B0000, 0, 0);
    add("resv",        exc(32'h1c00003C, 17'h400, 0), 0, 6, 0, 1, 32'h1c008000);
    add("resv_estat",  crd(ESTAT), 1, 1, 32'h000D0000, 0, 0);
    add("int_pri",     exc(32'h1c000044, 17'h23, 32'h77), 0, 6, 0, 1, 32'h1c008000);
    add("int_estat",   crd(ESTAT), 1, 1, 32'h0, 0, 0);
    add("int_badv",    crd(BADV),  1, 1, 32'h1c000002, 0, 0);
    add("int_era",     crd(ERA),   1, 1, 32'h1c000044, 0, 0);
    add("ecfg_w",      cwr(ECFG, 32'hFFFFFFFF), 1, 2, 32'h0, 0, 0);
    add("ecfg_rd",     crd(ECFG),  1, 1, 32'h0BFF, 0, 0);
    add("estat_w",     cwr(ESTAT, 32'hFFFFFFFF), 1, 2, 32'h0, 0, 0);
    add("estat_rd",    crd(ESTAT), 1, 1, 32'h3, 0, 0);
    add("tid_w",       cwr(TID, 32'hABCD), 1, 2, 32'h0, 0, 0);
    add("rdcntid",     mk(32'h1c000050, 1, 5'd9, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 1), 1, 9, 32'hABCD, 0, 0);
    add("unmap_w",     cwr(14'h10, 32'h5), 1, 2, 32'h0, 0, 0);
    add("unmap_rd",    crd(14'h10), 1, 1, 32'h0, 0, 0);

    foreach (tv[i]) begin
      b = tv[i].bus;
      issue(1'b1, b);
      exp_csr = b[134] | b[133];
      chk({tv[i].name, ".rf_we"},  32'(rf_we), 32'(tv[i].we));
      chk({tv[i].name, ".flush"},  32'(ws_reflush_ms), 32'(tv[i].fl));
      chk({tv[i].name, ".ws_csr"}, 32'(ws_csr), 32'(exp_csr));
      chk({tv[i].name, ".dbg_pc"}, debug_wb_pc, b[31:0]);
      chk({tv[i].name, ".dbg_we"}, 32'(debug_wb_rf_we), tv[i].we ? 32'hF : 32'h0);
      chk({tv[i].name, ".fwd_dest"}, 32'(ws_to_ds_dest), tv[i].we ? 32'(tv[i].wa) : 32'h0);
      chk({tv[i].name, ".fwd_val"},  ws_to_ds_value, tv[i].we ? tv[i].wd : 32'h0);
      if (tv[i].we) begin
        chk({tv[i].name, ".waddr"}, 32'(rf_waddr), 32'(tv[i].wa));
        chk({tv[i].name, ".wdata"}, rf_wdata, tv[i].wd);
      end
      if (tv[i].fl) chk({tv[i].name, ".flush_pc"}, flush_pc, tv[i].fpc);
    end

    // has_int follows CRMD.IE one cycle after the write commits.
    issue(1'b1, cwr(CRMD, 32'h4));
    chk("ie_w.old", rf_wdata, 32'h0);
    issue(1'b0, '0);
    chk("ie.bubble_we", 32'(rf_we), 32'd0);
    chk("ie.has_int_lag", 32'(has_int), 32'd0);
    issue(1'b0, '0);
    chk("ie.has_int", 32'(has_int), 32'd1);
    issue(1'b1, cwr(ESTAT, 32'h0));
    chk("estat_clr.old", rf_wdata, 32'h3);
    issue(1'b1, cwr(ECFG, 32'h800));
    chk("ecfg_ti.old", rf_wdata, 32'h0BFF);
    issue(1'b0, '0);
    chk("clr.has_int", 32'(has_int), 32'd0);

    // Periodic timer: InitVal=2, En, Periodic -> 8..0 then reload.
    issue(1'b1, cwr(TCFG, 32'h0000000B));
    chk("tcfg.old", rf_wdata, 32'h0);
    for (int k = 0; k < 10; k++) begin
      issue(1'b1, crd(TVAL));
      chk($sformatf("tval%0d", k), rf_wdata, (k <= 8) ? 32'(8 - k) : 32'd8);
      chk($sformatf("tint%0d", k), 32'(has_int), (k == 9) ? 32'd1 : 32'd0);
    end
    issue(1'b1, crd(ESTAT));
    chk("ti.estat", rf_wdata, 32'h800);
    issue(1'b1, cwr(TICLR, 32'h1));
    chk("ticlr.rd", rf_wdata, 32'h0);
    issue(1'b1, crd(ESTAT));
    chk("ticlr.estat", rf_wdata, 32'h0);
    issue(1'b1, cwr(TCFG, 32'h0));
    chk("tcfg0.old", rf_wdata, 32'hB);
    issue(1'b1, crd(TVAL));
    chk("tcfg_wins", rf_wdata, 32'h0);
    chk("ticlr.has_int", 32'(has_int), 32'd0);
    issue(1'b1, cwr(TVAL, 32'h1234));
    issue(1'b1, crd(TVAL));
    chk("tval_ro", rf_wdata, 32'h0);

    // One-shot: TICLR lands on the same edge as the 1->0 tick; the tick must win.
    issue(1'b1, cwr(TCFG, 32'h5));
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, crd(TVAL));
      chk($sformatf("os_tval%0d", k), rf_wdata, 32'(4 - k));
    end
    issue(1'b1, cwr(TICLR, 32'h1));
    issue(1'b1, crd(ESTAT));
    chk("ti_beats_clr", rf_wdata, 32'h800);
    issue(1'b1, crd(TVAL));
    chk("os_hold0", rf_wdata, 32'h0);
    issue(1'b1, crd(TVAL));
    chk("os_hold1", rf_wdata, 32'h0);

    hw_int_in = 8'h5A;
    issue(1'b1, crd(ESTAT));
    chk("hw.estat", rf_wdata, 32'h968);
    issue(1'b1, cwr(ESTAT, 32'h0));
    chk("hw_w.old", rf_wdata, 32'h968);
    issue(1'b1, crd(ESTAT));
    chk("hw_wins", rf_wdata, 32'h968);
    chk("ti.has_int", 32'(has_int), 32'd1);
    hw_int_in = 8'h0;

    // Reset asserted while a valid instruction arrives.
    @(negedge clk);
    reset = 1'b1;
    ms_ws.ms_to_ws_valid = 1'b1;
    ms_ws.ms_to_ws_bus   = alu(32'h1c000060, 5'd5, 32'h99);
    @(posedge clk); #1;
    chk("mid_rst.rf_we",   32'(rf_we), 32'd0);
    chk("mid_rst.has_int", 32'(has_int), 32'd0);
    chk("mid_rst.flush",   32'(ws_reflush_ms), 32'd0);
    chk("mid_rst.dbg_pc",  debug_wb_pc, 32'h0);
    @(negedge clk); reset = 1'b0;
    issue(1'b1, crd(CRMD));
    chk("post_rst.crmd", rf_wdata, 32'h8);
    issue(1'b1, crd(TVAL));
    chk("post_rst.tval", rf_wdata, 32'hFFFFFFFF);
    issue(1'b1, crd(ESTAT));
    chk("post_rst.estat", rf_wdata, 32'h0);
    issue(1'b1, crd(SAVE0));
    chk("post_rst.save0", rf_wdata, 32'h0);
    issue(1'b1, ertn_i(32'h1c000070));
    chk("ertn2.flush", 32'(ws_reflush_ms), 32'd1);
    chk("ertn2.fpc", flush_pc, 32'h0);
    issue(1'b0, '0);
    chk("ertn2.bubble_flush", 32'(ws_reflush_ms), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
